// File: rtl/dm_pkg.sv
// Debug module shared types.
// Contents:
//   sba_state_e - state encoding of the system-bus access engine
//   sberror_e   - sbcs.sberror codes
//   sbcs_t      - sbcs register layout, assembled by the DMI register file
package dm;

   typedef enum logic [2:0] {
      Idle      = 3'd0,
      Read      = 3'd1,
      Write     = 3'd2,
      WaitRead  = 3'd3,
      WaitWrite = 3'd4
   } sba_state_e;

   typedef enum logic [2:0] {
      None    = 3'd0,
      Timeout = 3'd1,
      BadAddr = 3'd2,
      Align   = 3'd3,
      Size    = 3'd4,
      Other   = 3'd7
   } sberror_e;

   typedef struct packed {
      logic [2:0] sbversion;
      logic [5:0] zero0;
      logic       sbbusyerror;
      logic       sbbusy;
      logic       sbreadonaddr;
      logic [2:0] sbaccess;
      logic       sbautoincrement;
      logic       sbreadondata;
      logic [2:0] sberror;
      logic [6:0] sbasize;
      logic       sbaccess128;
      logic       sbaccess64;
      logic       sbaccess32;
      logic       sbaccess16;
      logic       sbaccess8;
   } sbcs_t;

endpackage

// File: rtl/dm_sb_lane_align.sv
// Byte-lane steering between the sbdata register and the host bus word.
// Ports:
//   req_off/req_size/req_data - byte offset, log2 size and sbdata of a request
//   req_be/req_wdata          - byte enables and lane-shifted write data
//   rsp_off/rsp_size/rsp_rdata- offset and size latched at request time, bus read word
//   rsp_data                  - read data shifted down to bit 0, masked, zero-extended
// Purely combinational. req_size is only meaningful when it does not exceed
// log2(BusWidth/8); larger values are screened out before any request is issued.
module dm_sb_lane_align #(
   parameter int unsigned BusWidth = 32
) (
   input  logic [$clog2(BusWidth/8)-1:0] req_off,
   input  logic [2:0]                    req_size,
   input  logic [BusWidth-1:0]           req_data,
   output logic [BusWidth/8-1:0]         req_be,
   output logic [BusWidth-1:0]           req_wdata,
   input  logic [$clog2(BusWidth/8)-1:0] rsp_off,
   input  logic [2:0]                    rsp_size,
   input  logic [BusWidth-1:0]           rsp_rdata,
   output logic [BusWidth-1:0]           rsp_data
);

   localparam int unsigned NumBytes = BusWidth / 8;

   logic [BusWidth-1:0] rsp_shifted;

   assign req_wdata   = req_data << {req_off, 3'b000};
   assign rsp_shifted = rsp_rdata >> {rsp_off, 3'b000};

   always_comb begin
      req_be   = '0;
      rsp_data = '0;
      for (int b = 0; b < int'(NumBytes); b++) begin
         // A lane is enabled when it lies in [off, off + 2**size).
         if ((b >= int'(req_off)) && (b < int'(req_off) + (1 << req_size))) begin
            req_be[b] = 1'b1;
         end
         if (b < (1 << rsp_size)) begin
            rsp_data[8*b +: 8] = rsp_shifted[8*b +: 8];
         end
      end
   end

endmodule

// File: rtl/dm_sb_access_fsm.sv
// System-bus access engine of the debug module.
// Turns sbaddress/sbdata/sbcs accesses from the DMI register file into single-beat
// requests on a req/gnt/rvalid host port and returns read data and status.
// Ports:
//   clk_i, rst_i (sync, active-high), dmactive_i (low = soft clear)
//   sbaddress_i/_we_i, sbdata_i/_we_i/_re_i, sbaccess_i, sbreadonaddr_i,
//   sbreadondata_i, sbautoincrement_i, sberror_clr_i, sbbusyerror_clr_i - register file side
//   sbaddress_o, sbdata_o, sbbusy_o, sbbusyerror_o, sberror_o         - status back to it
//   req_o, addr_o, we_o, be_o, wdata_o, gnt_i, rvalid_i, rdata_i, err_i - host port
//   sba_state_o - current FSM state, for debug observation
// Host handshake: req_o and its addr/we/be/wdata are held stable until a cycle
// with gnt_i high (which may be the first cycle of req_o); exactly one rvalid_i
// follows, at least one cycle after the grant, with err_i qualified by rvalid_i.
module dm_sb_access_fsm
   import dm::*;
#(
   parameter int unsigned BusWidth = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  dmactive_i,
   input  logic [BusWidth-1:0]   sbaddress_i,
   input  logic                  sbaddress_we_i,
   input  logic [BusWidth-1:0]   sbdata_i,
   input  logic                  sbdata_we_i,
   input  logic                  sbdata_re_i,
   input  logic [2:0]            sbaccess_i,
   input  logic                  sbreadonaddr_i,
   input  logic                  sbreadondata_i,
   input  logic                  sbautoincrement_i,
   input  logic [2:0]            sberror_clr_i,
   input  logic                  sbbusyerror_clr_i,
   output logic [BusWidth-1:0]   sbaddress_o,
   output logic [BusWidth-1:0]   sbdata_o,
   output logic                  sbbusy_o,
   output logic                  sbbusyerror_o,
   output logic [2:0]            sberror_o,
   output logic                  req_o,
   output logic [BusWidth-1:0]   addr_o,
   output logic                  we_o,
   output logic [BusWidth/8-1:0] be_o,
   output logic [BusWidth-1:0]   wdata_o,
   input  logic                  gnt_i,
   input  logic                  rvalid_i,
   input  logic [BusWidth-1:0]   rdata_i,
   input  logic                  err_i,
   output sba_state_e            sba_state_o
);

   localparam int unsigned NumBytes  = BusWidth / 8;
   localparam int unsigned OffW      = $clog2(NumBytes);
   localparam logic [2:0]  MaxAccess = 3'(OffW);

   sba_state_e          state_q;
   logic [BusWidth-1:0] sbaddress_q;
   logic [BusWidth-1:0] sbdata_q;
   logic                sbbusyerror_q;
   logic [2:0]          sberror_q;
   logic                req_q;
   logic                we_q;
   logic [BusWidth-1:0] addr_q;
   logic [NumBytes-1:0] be_q;
   logic [BusWidth-1:0] wdata_q;
   logic [2:0]          acc_size_q;
   logic [OffW-1:0]     acc_off_q;
   logic                drop_q;     // response belongs to a transfer cancelled by dmactive

   logic                busy;
   logic                start_read;
   logic                start_write;
   logic                busy_hit;
   logic                start_ok;
   logic                size_err;
   logic                align_err;
   logic                issue;
   logic [BusWidth-1:0] start_addr;
   logic [BusWidth-1:0] start_data;
   logic [NumBytes-1:0] be_next;
   logic [BusWidth-1:0] wdata_next;
   logic [BusWidth-1:0] rdata_ext;

   assign busy        = (state_q != Idle);
   assign start_read  = (sbaddress_we_i && sbreadonaddr_i) || (sbdata_re_i && sbreadondata_i);
   assign start_write = sbdata_we_i;
   // Any start, or an address write, arriving mid-transfer is an sbbusyerror.
   assign busy_hit    = busy && (start_read || start_write || sbaddress_we_i);
   assign start_ok    = !busy && (start_read || start_write) && dmactive_i &&
                        !sbbusyerror_q && (sberror_q == 3'd0);
   // A start uses the value being loaded in the same cycle.
   assign start_addr  = sbaddress_we_i ? sbaddress_i : sbaddress_q;
   assign start_data  = sbdata_we_i ? sbdata_i : sbdata_q;
   assign size_err    = (sbaccess_i > MaxAccess);
   assign issue       = start_ok && !size_err && !align_err;

   always_comb begin
      align_err = 1'b0;
      for (int i = 0; i < int'(OffW); i++) begin
         if (i < int'(sbaccess_i)) begin
            align_err = align_err | start_addr[i];
         end
      end
   end

   dm_sb_lane_align #(
      .BusWidth (BusWidth)
   ) u_lane_align (
      .req_off   (start_addr[OffW-1:0]),
      .req_size  (sbaccess_i),
      .req_data  (start_data),
      .req_be    (be_next),
      .req_wdata (wdata_next),
      .rsp_off   (acc_off_q),
      .rsp_size  (acc_size_q),
      .rsp_rdata (rdata_i),
      .rsp_data  (rdata_ext)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= Idle;
         sbaddress_q   <= '0;
         sbdata_q      <= '0;
         sbbusyerror_q <= 1'b0;
         sberror_q     <= 3'd0;
         req_q         <= 1'b0;
         we_q          <= 1'b0;
         addr_q        <= '0;
         be_q          <= '0;
         wdata_q       <= '0;
         acc_size_q    <= 3'd0;
         acc_off_q     <= '0;
         drop_q        <= 1'b0;
      end else begin
         // Clears are applied first so that a new error in this cycle wins.
         sberror_q <= sberror_q & ~sberror_clr_i;
         if (sbbusyerror_clr_i) begin
            sbbusyerror_q <= 1'b0;
         end
         if (busy_hit) begin
            sbbusyerror_q <= 1'b1;
         end

         if (!busy && dmactive_i) begin
            if (sbaddress_we_i) begin
               sbaddress_q <= sbaddress_i;
            end
            if (sbdata_we_i) begin
               sbdata_q <= sbdata_i;
            end
         end

         if (start_ok && size_err) begin
            sberror_q <= Size;
         end else if (start_ok && align_err) begin
            sberror_q <= Align;
         end

         if (busy && !dmactive_i) begin
            drop_q <= 1'b1;
         end

         case (state_q)
            Idle: begin
               if (issue) begin
                  req_q      <= 1'b1;
                  we_q       <= start_write;
                  addr_q     <= {start_addr[BusWidth-1:OffW], {OffW{1'b0}}};
                  be_q       <= be_next;
                  wdata_q    <= start_write ? wdata_next : '0;
                  acc_size_q <= sbaccess_i;
                  acc_off_q  <= start_addr[OffW-1:0];
                  drop_q     <= 1'b0;
                  state_q    <= start_write ? Write : Read;
               end
            end
            Read, Write: begin
               if (gnt_i) begin
                  req_q   <= 1'b0;
                  we_q    <= 1'b0;
                  be_q    <= '0;
                  wdata_q <= '0;
                  state_q <= (state_q == Read) ? WaitRead : WaitWrite;
               end
            end
            WaitRead, WaitWrite: begin
               if (rvalid_i) begin
                  state_q <= Idle;
                  if (!drop_q && dmactive_i) begin
                     if (err_i) begin
                        sberror_q <= BadAddr;
                     end else begin
                        if (state_q == WaitRead) begin
                           sbdata_q <= rdata_ext;
                        end
                        if (sbautoincrement_i) begin
                           sbaddress_q <= sbaddress_q + (BusWidth'(1) << acc_size_q);
                        end
                     end
                  end
               end
            end
            default: begin
               state_q <= Idle;
            end
         endcase

         // Soft clear overrides everything above; the FSM itself keeps running
         // so that an outstanding grant/response is still consumed.
         if (!dmactive_i) begin
            sbaddress_q   <= '0;
            sbdata_q      <= '0;
            sberror_q     <= 3'd0;
            sbbusyerror_q <= 1'b0;
         end
      end
   end

   assign sbaddress_o   = sbaddress_q;
   assign sbdata_o      = sbdata_q;
   assign sbbusy_o      = busy;
   assign sbbusyerror_o = sbbusyerror_q;
   assign sberror_o     = sberror_q;
   assign req_o         = req_q;
   assign addr_o        = addr_q;
   assign we_o          = we_q;
   assign be_o          = be_q;
   assign wdata_o       = wdata_q;
   assign sba_state_o   = state_q;

endmodule

// File: tb/tb_dm_sb_access_fsm.sv
module tb_dm_sb_access_fsm;

   localparam int W = 32 + 1 + 4 + 32;  // {addr, we, be, wdata} of one bus request

   logic        clk = 1'b0;
   logic        rst_i;
   logic        dmactive_i;
   logic [31:0] sbaddress_i;
   logic        sbaddress_we_i;
   logic [31:0] sbdata_i;
   logic        sbdata_we_i;
   logic        sbdata_re_i;
   logic [2:0]  sbaccess_i;
   logic        sbreadonaddr_i;
   logic        sbreadondata_i;
   logic        sbautoincrement_i;
   logic [2:0]  sberror_clr_i;
   logic        sbbusyerror_clr_i;
   logic [31:0] sbaddress_o;
   logic [31:0] sbdata_o;
   logic        sbbusy_o;
   logic        sbbusyerror_o;
   logic [2:0]  sberror_o;
   logic        req_o;
   logic [31:0] addr_o;
   logic        we_o;
   logic [3:0]  be_o;
   logic [31:0] wdata_o;
   logic        gnt_i;
   logic        rvalid_i;
   logic [31:0] rdata_i;
   logic        err_i;
   logic [2:0]  sba_state_o;

   // host model knobs
   int          gnt_delay = 0;
   logic [31:0] host_rdata = '0;
   logic        host_err = 1'b0;
   int          req_count = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] got_item;
   logic [W-1:0] exp_item;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int fail_cnt = 0;
   int rc0;

   always #5 clk = ~clk;

   dm_sb_access_fsm #(.BusWidth(32)) dut (
      .clk_i             (clk),
      .rst_i             (rst_i),
      .dmactive_i        (dmactive_i),
      .sbaddress_i       (sbaddress_i),
      .sbaddress_we_i    (sbaddress_we_i),
      .sbdata_i          (sbdata_i),
      .sbdata_we_i       (sbdata_we_i),
      .sbdata_re_i       (sbdata_re_i),
      .sbaccess_i        (sbaccess_i),
      .sbreadonaddr_i    (sbreadonaddr_i),
      .sbreadondata_i    (sbreadondata_i),
      .sbautoincrement_i (sbautoincrement_i),
      .sberror_clr_i     (sberror_clr_i),
      .sbbusyerror_clr_i (sbbusyerror_clr_i),
      .sbaddress_o       (sbaddress_o),
      .sbdata_o          (sbdata_o),
      .sbbusy_o          (sbbusy_o),
      .sbbusyerror_o     (sbbusyerror_o),
      .sberror_o         (sberror_o),
      .req_o             (req_o),
      .addr_o            (addr_o),
      .we_o              (we_o),
      .be_o              (be_o),
      .wdata_o           (wdata_o),
      .gnt_i             (gnt_i),
      .rvalid_i          (rvalid_i),
      .rdata_i           (rdata_i),
      .err_i             (err_i),
      .sba_state_o       (sba_state_o)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] mk(input logic [31:0] a, input logic we,
                                       input logic [3:0] be, input logic [31:0] wd);
      return {a, we, be, (we ? wd : 32'h0)};
   endfunction

   // ---------------- driver tasks (entered and left at a negedge) ----------------
   task automatic write_addr(input logic [31:0] a);
      sbaddress_i    = a;
      sbaddress_we_i = 1'b1;
      @(negedge clk);
      sbaddress_we_i = 1'b0;
   endtask

   task automatic write_data(input logic [31:0] d);
      sbdata_i    = d;
      sbdata_we_i = 1'b1;
      @(negedge clk);
      sbdata_we_i = 1'b0;
   endtask

   task automatic read_data();
      sbdata_re_i = 1'b1;
      @(negedge clk);
      sbdata_re_i = 1'b0;
   endtask

   task automatic clear_err(input logic [2:0] m);
      sberror_clr_i = m;
      @(negedge clk);
      sberror_clr_i = 3'd0;
   endtask

   task automatic wait_idle(input string tag, input int max);
      int n = 0;
      while (sbbusy_o && n < max) begin
         @(negedge clk);
         n++;
      end
      check(tag, sbbusy_o, 1'b0);
   endtask

   // ---------------- host responder + scoreboard compare at grant ----------------
   initial begin
      int cnt;
      int phase;
      cnt = 0;
      phase = 0;
      gnt_i = 1'b0;
      rvalid_i = 1'b0;
      rdata_i = '0;
      err_i = 1'b0;
      forever begin
         @(negedge clk);
         case (phase)
            0: begin
               if (req_o && !rst_i) begin
                  if (cnt >= gnt_delay) begin
                     gnt_i = 1'b1;
                     req_count++;
                     got_item = {addr_o, we_o, be_o, (we_o ? wdata_o : 32'h0)};
                     check("bus_req_expected", exp_q.size() != 0, 1'b1);
                     if (exp_q.size() != 0) begin
                        exp_item = exp_q.pop_front();
                        check("bus_req", got_item, exp_item);
                     end
                     cnt = 0;
                     phase = 1;
                  end else begin
                     cnt++;
                  end
               end
            end
            1: begin
               gnt_i    = 1'b0;
               rvalid_i = 1'b1;
               rdata_i  = host_rdata;
               err_i    = host_err;
               phase    = 2;
            end
            default: begin
               rvalid_i = 1'b0;
               err_i    = 1'b0;
               rdata_i  = '0;
               phase    = 0;
            end
         endcase
      end
   end

   // the three DMI pulses never coincide
   always @(posedge clk) begin
      if (!rst_i) begin
         assert ($onehot0({sbaddress_we_i, sbdata_we_i, sbdata_re_i}))
         else begin
            chk_cnt++;
            fail_cnt++;
            $error("FAIL pulse_mutex: observed %b expected onehot0",
                   {sbaddress_we_i, sbdata_we_i, sbdata_re_i});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   initial begin
      rst_i = 1'b1;
      dmactive_i = 1'b0;
      sbaddress_i = '0;
      sbaddress_we_i = 1'b0;
      sbdata_i = '0;
      sbdata_we_i = 1'b0;
      sbdata_re_i = 1'b0;
      sbaccess_i = 3'd2;
      sbreadonaddr_i = 1'b0;
      sbreadondata_i = 1'b0;
      sbautoincrement_i = 1'b0;
      sberror_clr_i = 3'd0;
      sbbusyerror_clr_i = 1'b0;
      repeat (3) @(negedge clk);

      // reset state
      check("rst_sbaddress", sbaddress_o, 32'h0);
      check("rst_sbdata", sbdata_o, 32'h0);
      check("rst_status", {sbbusy_o, sbbusyerror_o, sberror_o}, 5'h0);
      check("rst_bus", {req_o, addr_o, we_o, be_o, wdata_o}, 70'h0);
      rst_i = 1'b0;
      dmactive_i = 1'b1;
      @(negedge clk);

      // word write 0xDEADBEEF to 0x1000
      sbaccess_i = 3'd2;
      write_addr(32'h1000);
      check("addr_load", sbaddress_o, 32'h1000);
      check("addr_load_no_req", req_o, 1'b0);
      exp_q.push_back(mk(32'h1000, 1'b1, 4'hF, 32'hDEADBEEF));
      write_data(32'hDEADBEEF);
      check("wr_req_next_cycle", {req_o, we_o, be_o}, {1'b1, 1'b1, 4'hF});
      @(negedge clk);
      check("wr_busy_in_wait", sbbusy_o, 1'b1);
      @(negedge clk);
      check("wr_busy_drops", sbbusy_o, 1'b0);

      // byte read on address write, top lane
      sbreadonaddr_i = 1'b1;
      sbaccess_i = 3'd0;
      host_rdata = 32'hAABBCCDD;
      exp_q.push_back(mk(32'h1000, 1'b0, 4'h8, 32'h0));
      write_addr(32'h1003);
      check("rd_byte_be", be_o, 4'h8);
      wait_idle("rd_byte_done", 20);
      check("rd_byte_data", sbdata_o, 32'h000000AA);

      // halfword read from upper half
      sbaccess_i = 3'd1;
      exp_q.push_back(mk(32'h1000, 1'b0, 4'hC, 32'h0));
      write_addr(32'h1002);
      wait_idle("rd_half_done", 20);
      check("rd_half_data", sbdata_o, 32'h0000AABB);
      sbreadonaddr_i = 1'b0;

      // byte write at lane 2
      sbaccess_i = 3'd0;
      write_addr(32'h1002);
      exp_q.push_back(mk(32'h1000, 1'b1, 4'h4, 32'h005A0000));
      write_data(32'h0000005A);
      wait_idle("wr_byte_done", 20);

      // autoincrement over three writes and across the top of memory
      sbaccess_i = 3'd2;
      sbautoincrement_i = 1'b1;
      write_addr(32'h2000);
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(mk(32'h2000 + 32'(4 * k), 1'b1, 4'hF, 32'hC0DE0000 + 32'(k)));
         write_data(32'hC0DE0000 + 32'(k));
         wait_idle("autoinc_done", 20);
      end
      check("autoinc_addr", sbaddress_o, 32'h200C);
      write_addr(32'hFFFFFFFC);
      exp_q.push_back(mk(32'hFFFFFFFC, 1'b1, 4'hF, 32'h0BADF00D));
      write_data(32'h0BADF00D);
      wait_idle("wrap_done", 20);
      check("autoinc_wrap", sbaddress_o, 32'h0);
      sbautoincrement_i = 1'b0;

      // misaligned halfword: error 3, no bus access; sticky against a size error
      rc0 = req_count;
      sbaccess_i = 3'd1;
      write_addr(32'h1001);
      write_data(32'h1234);
      check("align_no_req", req_o, 1'b0);
      check("align_err", sberror_o, 3'd3);
      sbaccess_i = 3'd3;
      write_data(32'h5678);
      check("err_sticky", sberror_o, 3'd3);
      clear_err(3'h7);
      check("err_cleared", sberror_o, 3'd0);
      write_addr(32'h1000);
      write_data(32'h9ABC);
      check("size_err", sberror_o, 3'd4);
      clear_err(3'h7);
      check("prechk_no_bus", req_count, rc0);

      // second write while the first waits for grant
      sbaccess_i = 3'd2;
      gnt_delay = 5;
      rc0 = req_count;
      write_addr(32'h3000);
      exp_q.push_back(mk(32'h3000, 1'b1, 4'hF, 32'h11111111));
      write_data(32'h11111111);
      write_data(32'h22222222);
      check("busyerror_set", sbbusyerror_o, 1'b1);
      wait_idle("busy_wr_done", 40);
      check("busy_one_req", req_count, rc0 + 1);
      check("busy_data_kept", sbdata_o, 32'h11111111);
      gnt_delay = 0;
      write_data(32'h33333333);
      check("busyerr_blocks_start", {req_o, sbbusy_o}, 2'b00);
      check("busyerr_still_loads", sbdata_o, 32'h33333333);
      sbbusyerror_clr_i = 1'b1;
      @(negedge clk);
      sbbusyerror_clr_i = 1'b0;
      check("busyerror_cleared", sbbusyerror_o, 1'b0);
      check("busyerr_no_req", req_count, rc0 + 1);

      // bus error: code 2, no autoincrement
      sbautoincrement_i = 1'b1;
      host_err = 1'b1;
      write_addr(32'h4000);
      exp_q.push_back(mk(32'h4000, 1'b1, 4'hF, 32'h44444444));
      write_data(32'h44444444);
      wait_idle("buserr_done", 20);
      host_err = 1'b0;
      check("buserr_code", sberror_o, 3'd2);
      check("buserr_no_inc", sbaddress_o, 32'h4000);
      clear_err(3'h2);
      check("buserr_cleared", sberror_o, 3'd0);
      sbautoincrement_i = 1'b0;

      // read on sbdata read
      sbreadondata_i = 1'b1;
      host_rdata = 32'h12345678;
      exp_q.push_back(mk(32'h4000, 1'b0, 4'hF, 32'h0));
      read_data();
      check("rod_req", req_o, 1'b1);
      wait_idle("rod_done", 20);
      check("rod_data", sbdata_o, 32'h12345678);
      sbreadondata_i = 1'b0;

      // soft clear while waiting for read data
      sbreadonaddr_i = 1'b1;
      host_rdata = 32'h55AA55AA;
      exp_q.push_back(mk(32'h5000, 1'b0, 4'hF, 32'h0));
      write_addr(32'h5000);
      @(negedge clk);
      check("dmact_in_waitread", sba_state_o, 3'd3);
      dmactive_i = 1'b0;
      @(negedge clk);
      check("dmact_consumed", sbbusy_o, 1'b0);
      check("dmact_regs_zero", {sbaddress_o, sbdata_o}, 64'h0);
      check("dmact_errs_zero", {sbbusyerror_o, sberror_o}, 4'h0);
      rc0 = req_count;
      sbreadonaddr_i = 1'b0;
      write_data(32'h77777777);
      check("dmact_no_start", {req_o, sbdata_o}, 33'h0);
      @(negedge clk);
      check("dmact_no_req", req_count, rc0);
      dmactive_i = 1'b1;
      @(negedge clk);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
